// File: rtl/cordic_vector_if.sv
// Request/result bundle for the CORDIC vectoring block.
interface cordic_vector_if #(parameter int WIDTH = 24);
  logic             start;
  logic [WIDTH-1:0] fixedPoint_x;
  logic [WIDTH-1:0] fixedPoint_y;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] fixedPoint_angle;
  logic [WIDTH-1:0] fixedPoint_mag;

  modport master (output start, fixedPoint_x, fixedPoint_y,
                  input  busy, done, err, fixedPoint_angle, fixedPoint_mag);
  modport slave  (input  start, fixedPoint_x, fixedPoint_y,
                  output busy, done, err, fixedPoint_angle, fixedPoint_mag);
endinterface

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring: (x,y) -> atan(y/x) and gain-compensated magnitude.
// ITERS_PER_STAGE micro-rotations are chained combinationally per enabled clock.
module cordic_vector #(
  parameter int FRACS           = 22,
  parameter int INTS            = 1,
  parameter int WIDTH           = INTS + FRACS + 1,
  parameter int ITERATIONS      = 16,
  parameter int ITERS_PER_STAGE = 4
) (
  input logic          clk,
  input logic          reset,
  input logic          clk_en,
  cordic_vector_if.slave bus
);
  localparam int IW     = WIDTH + 2;
  localparam int STAGES = ITERATIONS / ITERS_PER_STAGE;
  localparam int CW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int SHL    = (FRACS >= 22) ? FRACS - 22 : 0;
  localparam int SHR    = (FRACS < 22) ? 22 - FRACS : 0;

  // Constants are tabulated with 22 fraction bits and rescaled to FRACS.
  function automatic logic [IW-1:0] q22(input logic [63:0] t);
    logic [63:0] s;
    s = (t << SHL) >> SHR;
    return s[IW-1:0];
  endfunction

  function automatic logic [IW-1:0] atan_c(input logic [7:0] i);
    logic [63:0] t;
    case (i)
      8'd0:  t = 64'h3243F6;
      8'd1:  t = 64'h1DAC67;
      8'd2:  t = 64'h0FADBB;
      8'd3:  t = 64'h07F56F;
      8'd4:  t = 64'h03FEAB;
      8'd5:  t = 64'h01FFD5;
      8'd6:  t = 64'h00FFFB;
      8'd7:  t = 64'h007FFF;
      8'd8:  t = 64'h004000;
      8'd9:  t = 64'h002000;
      8'd10: t = 64'h001000;
      8'd11: t = 64'h000800;
      8'd12: t = 64'h000400;
      8'd13: t = 64'h000200;
      8'd14: t = 64'h000100;
      8'd15: t = 64'h000080;
      8'd16: t = 64'h000040;
      8'd17: t = 64'h000020;
      8'd18: t = 64'h000010;
      8'd19: t = 64'h000008;
      8'd20: t = 64'h000004;
      8'd21: t = 64'h000002;
      8'd22: t = 64'h000001;
      default: t = '0;
    endcase
    return q22(t);
  endfunction

  localparam logic signed [IW-1:0]   KC   = q22(64'h26DD3B);
  localparam logic signed [2*IW-1:0] MAXW = (2*IW)'((64'd1 << (WIDTH-1)) - 64'd1);

  typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic signed [IW-1:0]  x_r, y_r, z_r;
  logic                  err_q, zero_q, busy_r, done_r, err_r;
  logic [WIDTH-1:0]      ang_r, mag_r, mag_sat;
  logic signed [IW-1:0]  xc [ITERS_PER_STAGE+1];
  logic signed [IW-1:0]  yc [ITERS_PER_STAGE+1];
  logic signed [IW-1:0]  zc [ITERS_PER_STAGE+1];
  logic signed [2*IW-1:0] prod, prod_sh;

  assign xc[0] = x_r;
  assign yc[0] = y_r;
  assign zc[0] = z_r;

  for (genvar k = 0; k < ITERS_PER_STAGE; k++) begin : g_rot
    logic [7:0]           idx;
    logic signed [IW-1:0] at;
    logic                 neg;
    assign idx = 8'(cnt) * 8'(ITERS_PER_STAGE) + 8'(k);
    assign at  = atan_c(idx);
    assign neg = yc[k][IW-1];
    assign xc[k+1] = neg ? xc[k] - (yc[k] >>> idx) : xc[k] + (yc[k] >>> idx);
    assign yc[k+1] = neg ? yc[k] + (xc[k] >>> idx) : yc[k] - (xc[k] >>> idx);
    assign zc[k+1] = neg ? zc[k] - at : zc[k] + at;
  end

  // x_r holds the final x while in COMP; >>> floors toward -inf.
  assign prod    = x_r * KC;
  assign prod_sh = prod >>> FRACS;
  assign mag_sat = (prod_sh > MAXW) ? MAXW[WIDTH-1:0] : prod_sh[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      err_q  <= 1'b0;
      zero_q <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      ang_r  <= '0;
      mag_r  <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            x_r    <= {{2{bus.fixedPoint_x[WIDTH-1]}}, bus.fixedPoint_x};
            y_r    <= {{2{bus.fixedPoint_y[WIDTH-1]}}, bus.fixedPoint_y};
            z_r    <= '0;
            cnt    <= '0;
            err_q  <= bus.fixedPoint_x[WIDTH-1];
            zero_q <= (bus.fixedPoint_x == '0) && (bus.fixedPoint_y == '0);
            busy_r <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          x_r <= xc[ITERS_PER_STAGE];
          y_r <= yc[ITERS_PER_STAGE];
          z_r <= zc[ITERS_PER_STAGE];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(STAGES-1)) state <= COMP;
        end
        COMP: begin
          // A zero vector never moves y, so z would sum every table entry.
          ang_r  <= (err_q || zero_q) ? '0 : z_r[WIDTH-1:0];
          mag_r  <= err_q ? '0 : mag_sat;
          err_r  <= err_q;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.err              = err_r;
  assign bus.fixedPoint_angle = ang_r;
  assign bus.fixedPoint_mag   = mag_r;
endmodule

// File: tb/tb_cordic_vector.sv
// Randomized and directed checks of cordic_vector against a real-math model.
module tb_cordic_vector;
  localparam int FRACS = 22;
  localparam int WIDTH = 24;
  localparam real SC   = 4194304.0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  int   errs = 0;
  int   checks = 0;

  cordic_vector_if #(.WIDTH(WIDTH)) bus();

  cordic_vector dut (.clk(clk), .reset(rst_n), .clk_en(clk_en), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
    checks++;
    if (got - exp > tol || exp - got > tol) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint ref_ang(input longint x, input longint y);
    if (x < 0 || (x == 0 && y == 0)) return 0;
    return longint'($atan2(real'(y), real'(x)) * SC);
  endfunction

  function automatic longint ref_mag(input longint x, input longint y);
    if (x < 0) return 0;
    return longint'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
  endfunction

  function automatic longint s_ang();
    return longint'($signed(bus.fixedPoint_angle));
  endfunction

  function automatic longint s_mag();
    return longint'($signed(bus.fixedPoint_mag));
  endfunction

  // stall_at>0: clk_en low for 3 edges after cycle stall_at; rs_at>0: stray start
  task automatic run_op(input longint xi, input longint yi, input int stall_at,
                        input int rs_at, input bit gap,
                        output longint ang, output longint mag);
    int n;
    bit seen;
    longint ea, em, a_hold;
    ea = ref_ang(xi, yi);
    em = ref_mag(xi, yi);
    @(negedge clk);
    bus.start = 1'b1;
    bus.fixedPoint_x = WIDTH'(xi);
    bus.fixedPoint_y = WIDTH'(yi);
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
      else begin
        if (n == 1) chk("busy_run", longint'(bus.busy), 1, 0);
        if (stall_at > 0 && n == stall_at) clk_en = 1'b0;
        if (stall_at > 0 && n == stall_at + 3) clk_en = 1'b1;
        if (rs_at > 0 && n == rs_at) begin
          bus.start = 1'b1;
          bus.fixedPoint_x = 24'h100000;
          bus.fixedPoint_y = 24'h0F0000;
        end
        if (rs_at > 0 && n == rs_at + 1) bus.start = 1'b0;
      end
    end
    clk_en = 1'b1;
    bus.start = 1'b0;
    chk("latency", longint'(n), (stall_at > 0) ? 8 : 5, 0);
    ang = s_ang();
    mag = s_mag();
    chk("angle", ang, ea, 256);
    chk("mag", mag, em, 64);
    chk("err", longint'(bus.err), (xi < 0) ? 1 : 0, 0);
    if (gap) begin
      a_hold = ang;
      @(posedge clk);
      #1;
      chk("done_pulse", longint'(bus.done), 0, 0);
      chk("err_clear", longint'(bus.err), 0, 0);
      chk("busy_idle", longint'(bus.busy), 0, 0);
      chk("angle_hold", s_ang(), a_hold, 0);
    end
  endtask

  initial begin
    longint a, m, a0, m0, xr, yr;
    int any_done;
    bus.start = 1'b0;
    bus.fixedPoint_x = '0;
    bus.fixedPoint_y = '0;
    #3;
    chk("rst_busy", longint'(bus.busy), 0, 0);
    chk("rst_done", longint'(bus.done), 0, 0);
    chk("rst_err", longint'(bus.err), 0, 0);
    chk("rst_angle", s_ang(), 0, 0);
    chk("rst_mag", s_mag(), 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op(64'h200000, 0, 0, 0, 1'b1, a, m);
    run_op(64'h200000, 64'h200000, 0, 0, 1'b1, a, m);
    chk("diag_angle", a, 64'h3243F6, 256);
    chk("diag_mag", m, 64'h2D413D, 64);
    run_op(64'h200000, -64'h200000, 0, 0, 1'b1, a, m);
    chk("ndiag_angle", a, -64'h3243F6, 256);
    run_op(-64'h100000, 64'h100000, 0, 0, 1'b1, a, m);
    run_op(0, 0, 0, 0, 1'b1, a, m);
    run_op(64'h300000, -64'h120000, 0, 2, 1'b1, a, m);
    run_op(64'h180000, 64'h0A0000, 0, 0, 1'b0, a, m);
    run_op(64'h050000, -64'h3F0000, 0, 0, 1'b1, a, m);

    run_op(64'h2A0000, 64'h150000, 0, 0, 1'b1, a0, m0);
    run_op(64'h2A0000, 64'h150000, 2, 0, 1'b1, a, m);
    chk("stall_angle_eq", a, a0, 0);
    chk("stall_mag_eq", m, m0, 0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.fixedPoint_x = 24'h1C0000;
    bus.fixedPoint_y = 24'h0B0000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", longint'(bus.busy), 0, 0);
    chk("mid_rst_angle", s_ang(), 0, 0);
    chk("mid_rst_mag", s_mag(), 0, 0);
    any_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (bus.done) any_done++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1 if (bus.done) any_done++;
    end
    chk("mid_rst_no_done", longint'(any_done), 0, 0);
    run_op(64'h1C0000, 64'h0B0000, 0, 0, 1'b1, a, m);

    for (int i = 0; i < 24; i++) begin
      xr = longint'($urandom_range(0, 4194303));
      yr = longint'($urandom_range(0, 8388606)) - 4194303;
      if (i % 6 == 5) xr = -xr - 1;
      run_op(xr, yr, 0, 0, (i % 4 != 0), a, m);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
